// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice: FSM states, word type, sizes and xtime.
package aes_pkg;

    localparam int unsigned AES_NK = 4;
    localparam int unsigned AES_NR = 10;

    typedef logic [31:0] word_t;

    typedef enum logic {
        StIdle,
        StGen
    } state_t;

    // Multiply by x in GF(2^8), reducing by 0x11b.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] plain,
    output logic [7:0] subst
);

    localparam logic [0:255][7:0] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign subst = SboxTable[plain];

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion: one schedule word per cycle, round keys streamed every fourth cycle.
// Optional round-key store enabled by defining KEY_EXPAND_STORE_EN.
module key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic         o_busy,
    output logic         o_rk_valid,
    output logic [3:0]   o_rk_idx,
    output logic [127:0] o_rk,
    output logic         o_done,
    input  logic [3:0]   i_rd_idx,
    output logic [127:0] o_rd_key
);

    localparam logic [5:0] LastCnt = 6'(AES_NK * NUM_ROUNDS);

    state_t       state;
    word_t        win [AES_NK];
    logic [7:0]   rcon;
    logic [5:0]   cnt;
    logic         busy;
    logic         rk_valid;
    logic         done;
    logic [3:0]   rk_idx;
    logic [127:0] rk;

    word_t        rot_word;
    word_t        sub_word;
    word_t        temp;
    word_t        next_word;
    logic [127:0] win_flat;
    logic         emit;

    assign rot_word = {win[3][23:0], win[3][31:24]};

    for (genvar gb = 0; gb < 4; gb++) begin : g_sbox
        aes_sbox u_sbox (
            .plain(rot_word[8*gb +: 8]),
            .subst(sub_word[8*gb +: 8])
        );
    end

    // cnt counts GEN cycles; cnt%4==0 marks both a round-key boundary and an i%4==0 word.
    assign emit      = (state == StGen) && (cnt[1:0] == 2'd0);
    assign temp      = (cnt[1:0] == 2'd0) ? (sub_word ^ {rcon, 24'h0}) : win[3];
    assign next_word = win[0] ^ temp;
    assign win_flat  = {win[0], win[1], win[2], win[3]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= StIdle;
            for (int j = 0; j < AES_NK; j++) win[j] <= '0;
            rcon     <= 8'h01;
            cnt      <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
            rk_idx   <= '0;
            rk       <= '0;
        end else begin
            rk_valid <= 1'b0;
            done     <= 1'b0;
            unique case (state)
                StIdle: begin
                    busy <= i_start;
                    if (i_start) begin
                        win[0] <= i_key[127:96];
                        win[1] <= i_key[95:64];
                        win[2] <= i_key[63:32];
                        win[3] <= i_key[31:0];
                        rcon   <= 8'h01;
                        cnt    <= '0;
                        state  <= StGen;
                    end
                end
                StGen: begin
                    busy <= 1'b1;
                    if (emit) begin
                        rk_valid <= 1'b1;
                        rk       <= win_flat;
                        rk_idx   <= cnt[5:2];
                    end
                    if (cnt == LastCnt) begin
                        done  <= 1'b1;
                        state <= StIdle;
                    end else begin
                        win[0] <= win[1];
                        win[1] <= win[2];
                        win[2] <= win[3];
                        win[3] <= next_word;
                        cnt    <= cnt + 6'd1;
                        if (cnt[1:0] == 2'd0) rcon <= xtime(rcon);
                    end
                end
            endcase
        end
    end

    assign o_busy     = busy;
    assign o_rk_valid = rk_valid;
    assign o_rk_idx   = rk_idx;
    assign o_rk       = rk;
    assign o_done     = done;

`ifdef KEY_EXPAND_STORE_EN
    logic [127:0] store [NUM_ROUNDS + 1];
    logic [127:0] rd_key;

    always_ff @(posedge i_clk) begin
        if (emit) store[cnt[5:2]] <= win_flat;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_key <= '0;
        end else if (i_rd_idx <= 4'(NUM_ROUNDS)) begin
            rd_key <= store[i_rd_idx];
        end else begin
            rd_key <= '0;
        end
    end

    assign o_rd_key = rd_key;
`else
    logic unused_rd_idx;
    assign unused_rd_idx = ^i_rd_idx;
    assign o_rd_key      = '0;
`endif

endmodule

// File: doc/key_expand.md
KEY_EXPAND -- requirements
Module: key_expand

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning AES-128 round count; it is fixed at 10 and other values are unsupported.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_start, input, 1, start request.
REQ-005 SHALL have port i_key, input, 128, cipher key, MSB = first key byte.
REQ-006 SHALL have port o_busy, output, 1, high while an expansion is in progress.
REQ-007 SHALL have port o_rk_valid, output, 1, one-cycle strobe qualifying o_rk and o_rk_idx.
REQ-008 SHALL have port o_rk_idx, output, 4, round-key index 0..10.
REQ-009 SHALL have port o_rk, output, 128, round key.
REQ-010 SHALL have port o_done, output, 1, one-cycle strobe coincident with round key 10.
REQ-011 SHALL have port i_rd_idx, input, 4, stored-key read index (KEY_EXPAND_STORE_EN only).
REQ-012 SHALL have port o_rd_key, output, 128, stored-key read data (KEY_EXPAND_STORE_EN only).

Function
REQ-013 SHALL implement FSM states IDLE and GEN; reset state is IDLE.
REQ-014 IDLE with i_start=1 SHALL capture i_key as w0..w3, load rcon=0x01, enter GEN, and assert o_busy from the next cycle.
REQ-015 i_start while in GEN SHALL be ignored, and i_key SHALL NOT be resampled.
REQ-016 GEN SHALL compute one word w[i] per cycle for i=4..43: w[i]=w[i-4]^temp.
REQ-017 temp SHALL be SubWord(RotWord(w[i-1]))^{rcon,24'h0} when i%4==0, and w[i-1] otherwise.
REQ-018 rcon SHALL be xtime-updated after each i%4==0 word (0x01,02,..,80,1b,36); 0x80 SHALL wrap to 0x1b via the 0x11b reduction.
REQ-019 A 4-word sliding window SHALL hold w[i-4..i-1]; no 44-word array is kept unless KEY_EXPAND_STORE_EN is defined.
REQ-020 With the acceptance edge counted as cycle 0, round key r SHALL be presented with o_rk_valid=1 in cycle 1+4r (round 0 in cycle 1, round 10 in cycle 41).
REQ-021 o_done SHALL be high only in cycle 41; GEN SHALL return to IDLE so that o_busy=0 from cycle 42.
REQ-022 i_start in cycle 42 SHALL be accepted (back-to-back operation).
REQ-023 Outside valid cycles, o_rk and o_rk_idx SHALL hold their last values and o_rk_valid SHALL be 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 Asserting i_rst_n=0 SHALL immediately force IDLE, o_busy=0, o_rk_valid=0, o_done=0, o_rk=0, o_rk_idx=0, o_rd_key=0, rcon=0x01, and the window to 0.
REQ-026 Reset mid-expansion SHALL abort with no further strobes; the next i_start SHALL restart from round 0.
REQ-027 Reset and i_start together SHALL resolve to reset.

Configuration
REQ-028 Macro KEY_EXPAND_STORE_EN defined SHALL add an 11x128 round-key store written on each o_rk_valid, read with one-cycle latency: o_rd_key = store[i_rd_idx]; i_rd_idx>10 reads 0.
REQ-029 Without KEY_EXPAND_STORE_EN, o_rd_key SHALL be constant 0, i_rd_idx SHALL be unused, and no store SHALL be synthesised.

Structure
REQ-030 A shared package (aes_pkg) SHALL hold the state enum, the word typedef (32 bits), AES_NK=4, AES_NR=10, and the xtime function.
REQ-031 Sub-module aes_sbox SHALL be a combinational 8-bit S-box with 4 instances forming SubWord.

Verification
REQ-032 Key 2b7e151628aed2a6abf7158809cf4f3c -> idx1=a0fafe1788542cb123a339392a6c7605 in cycle 5; idx10=d014f9a8c9ee2589e13f0cc8b6630ca6 with o_done in cycle 41.
REQ-033 Key all-zero -> idx0=0, idx1=62636363626363636263636362636363.
REQ-034 i_start pulsed with a different key in cycle 10 -> ignored; all 11 keys match the first key.
REQ-035 i_rst_n pulsed low in cycle 22 -> outputs zero, no further strobes; restart yields correct idx0..idx10.
REQ-036 i_start in cycle 42 -> second expansion begins with no idle gap, and idx0 appears in cycle 43.
REQ-037 With KEY_EXPAND_STORE_EN after the REQ-032 run, i_rd_idx=10 -> o_rd_key=d014f9a8c9ee2589e13f0cc8b6630ca6 next cycle; i_rd_idx=15 -> 0.
